// File: rtl/button_debounce.sv
//-----------------------------------------------------------------------------
// button_debounce
//
// Purpose:
//   Cleans up a raw mechanical push-button signal. The raw level is brought
//   into the CLOCK_50 domain through a two-flop synchronizer. It is then
//   normalised so that 1 always means "pressed". A four-state FSM accepts a
//   level change only after the new level has been seen for DEBOUNCE_CYCLES
//   consecutive cycles. Accepted changes produce a registered debounced level,
//   one-cycle press/release pulses, a toggle that flips on every press, and an
//   8-bit press counter.
//
// Parameters:
//   DEBOUNCE_CYCLES - consecutive stable cycles needed to accept a change
//                     (2 .. 2^24; the default is 20 ms at 50 MHz)
//   BTN_ACTIVE_LOW  - 1: the raw input is low while pressed
//                     0: the raw input is high while pressed
//
// Ports:
//   CLOCK_50     in   sole clock, rising edge
//   reset        in   synchronous reset, active low
//   btn_in       in   raw asynchronous button level
//   btn_level    out  debounced level, 1 = pressed
//   btn_press    out  one-cycle pulse per accepted press
//   btn_release  out  one-cycle pulse per accepted release
//   press_toggle out  inverts on every accepted press
//   press_count  out  accepted presses, wraps 255 -> 0
//-----------------------------------------------------------------------------
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       btn_press,
  output logic       btn_release,
  output logic       press_toggle,
  output logic [7:0] press_count
);

  // The counter only has to reach DEBOUNCE_CYCLES-1, so clog2 gives exactly
  // the width needed. The guard keeps the width at least one bit.
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // This is the raw level the button shows while it is not pressed.
  localparam logic RAW_RELEASED = BTN_ACTIVE_LOW;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_CHK   = 2'd1,
    HELD        = 2'd2,
    RELEASE_CHK = 2'd3
  } state_t;

  logic             syncMeta_q;
  logic             syncOut_q;
  logic             sample_d;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // A press or release event is flagged on the edge that enters HELD or IDLE
  // from a check state. The event is then re-registered into the output
  // pulse, so all outputs change together one cycle after the state does.
  logic             pressEvt_q;
  logic             pressEvt_d;
  logic             releaseEvt_q;
  logic             releaseEvt_d;

  logic             btnLevel_q;
  logic             btnPress_q;
  logic             btnRelease_q;
  logic             pressToggle_q;
  logic [7:0]       pressCount_q;

  // The synchronized level is normalised so the FSM always sees 1 = pressed,
  // whichever way the button is wired.
  assign sample_d = syncOut_q ^ RAW_RELEASED;

  // Next-state logic for the qualification FSM. The counter runs only in the
  // two check states. It restarts from zero on any bounce. It stops at
  // CNT_LAST, where the change is accepted, so it can never wrap.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pressEvt_d   = 1'b0;
    releaseEvt_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (sample_d) begin
          state_d = PRESS_CHK;
        end
      end
      PRESS_CHK: begin
        if (!sample_d) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = HELD;
          cnt_d      = '0;
          pressEvt_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        cnt_d = '0;
        if (!sample_d) begin
          state_d = RELEASE_CHK;
        end
      end
      RELEASE_CHK: begin
        if (sample_d) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d      = IDLE;
          cnt_d        = '0;
          releaseEvt_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // All state lives here. Reset wins over everything else. It loads the
  // synchronizer with the released level, so a button held through reset
  // is qualified again from scratch. The debounced level follows the FSM
  // state one cycle later, which keeps it aligned with the press and release
  // pulses. The toggle and the counter update on the same edge as the press
  // pulse.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      syncMeta_q    <= RAW_RELEASED;
      syncOut_q     <= RAW_RELEASED;
      state_q       <= IDLE;
      cnt_q         <= '0;
      pressEvt_q    <= 1'b0;
      releaseEvt_q  <= 1'b0;
      btnLevel_q    <= 1'b0;
      btnPress_q    <= 1'b0;
      btnRelease_q  <= 1'b0;
      pressToggle_q <= 1'b0;
      pressCount_q  <= 8'd0;
    end else begin
      syncMeta_q    <= btn_in;
      syncOut_q     <= syncMeta_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pressEvt_q    <= pressEvt_d;
      releaseEvt_q  <= releaseEvt_d;
      btnLevel_q    <= (state_q == HELD) || (state_q == RELEASE_CHK);
      btnPress_q    <= pressEvt_q;
      btnRelease_q  <= releaseEvt_q;
      if (pressEvt_q) begin
        pressToggle_q <= ~pressToggle_q;
        pressCount_q  <= pressCount_q + 8'd1;
      end
    end
  end

  assign btn_level    = btnLevel_q;
  assign btn_press    = btnPress_q;
  assign btn_release  = btnRelease_q;
  assign press_toggle = pressToggle_q;
  assign press_count  = pressCount_q;

endmodule

// File: tb/tb_button_debounce.sv
//-----------------------------------------------------------------------------
// tb_button_debounce
//
// Purpose:
//   Directed bench for button_debounce with DEBOUNCE_CYCLES = 8 and an
//   active-low button. Inputs change 1 ns after a rising edge. Outputs are
//   sampled at the same point, so "edge index e" below means the e-th rising
//   edge after the input change, counting from 0. With DEBOUNCE_CYCLES = 8,
//   a pulse is expected at e = 8 + 3 = 11.
//-----------------------------------------------------------------------------
module tb_button_debounce;

  logic       clk;
  logic       rstN;
  logic       btnIn;
  logic       btnLevel;
  logic       btnPress;
  logic       btnRelease;
  logic       pressToggle;
  logic [7:0] pressCount;

  int checks;
  int errors;

  button_debounce #(
    .DEBOUNCE_CYCLES(8),
    .BTN_ACTIVE_LOW (1'b1)
  ) dut (
    .CLOCK_50    (clk),
    .reset       (rstN),
    .btn_in      (btnIn),
    .btn_level   (btnLevel),
    .btn_press   (btnPress),
    .btn_release (btnRelease),
    .press_toggle(pressToggle),
    .press_count (pressCount)
  );

  // Free-running 100 MHz clock; the period only matters relative to itself.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle 1 ns past it.
  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  // Drive the raw button level (0 = pressed for this active-low bench).
  task automatic applyStimulus(input logic level);
    btnIn = level;
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Step through a window of edges and require that the press and release
  // pulses fire only at the given edge indices (-1 means never).
  task automatic watchWindow(input string tag, input int cycles,
                             input int pressAt, input int releaseAt);
    for (int e = 0; e < cycles; e++) begin
      stepEdge();
      checkOutput($sformatf("%s_press_e%0d", tag, e), 8'(btnPress),
                  (e == pressAt) ? 8'd1 : 8'd0);
      checkOutput($sformatf("%s_release_e%0d", tag, e), 8'(btnRelease),
                  (e == releaseAt) ? 8'd1 : 8'd0);
    end
  endtask

  // Check the three steady outputs together.
  task automatic checkSteady(input string tag, input logic expLevel,
                             input logic expToggle, input logic [7:0] expCount);
    checkOutput({tag, "_level"}, 8'(btnLevel), 8'(expLevel));
    checkOutput({tag, "_toggle"}, 8'(pressToggle), 8'(expToggle));
    checkOutput({tag, "_count"}, pressCount, expCount);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Reset with the button released; every output must be zero.
    rstN = 1'b0;
    applyStimulus(1'b1);
    repeat (3) stepEdge();
    checkOutput("reset_press", 8'(btnPress), 8'd0);
    checkOutput("reset_release", 8'(btnRelease), 8'd0);
    checkSteady("reset", 1'b0, 1'b0, 8'd0);
    rstN = 1'b1;
    watchWindow("idle", 5, -1, -1);

    // Clean press: pulse at e=11; level, toggle and count then show the press.
    applyStimulus(1'b0);
    watchWindow("press", 20, 11, -1);
    checkSteady("press", 1'b1, 1'b1, 8'd1);

    // Clean release: pulse at e=11; the toggle is unchanged.
    applyStimulus(1'b1);
    watchWindow("release", 20, -1, 11);
    checkSteady("release", 1'b0, 1'b1, 8'd1);

    // A single-cycle low glitch must not change any output.
    applyStimulus(1'b0);
    stepEdge();
    applyStimulus(1'b1);
    watchWindow("glitch", 20, -1, -1);
    checkSteady("glitch", 1'b0, 1'b1, 8'd1);

    // Bounce: 3-cycle segments alternating low/high for 30 cycles, then
    // stable low. There is no pulse while bouncing, and one press 11 edges
    // after the final low.
    for (int seg = 0; seg < 10; seg++) begin
      applyStimulus((seg % 2 == 0) ? 1'b0 : 1'b1);
      for (int c = 0; c < 3; c++) begin
        stepEdge();
        checkOutput($sformatf("bounce_press_s%0d_c%0d", seg, c), 8'(btnPress), 8'd0);
        checkOutput($sformatf("bounce_release_s%0d_c%0d", seg, c), 8'(btnRelease), 8'd0);
      end
    end
    applyStimulus(1'b0);
    watchWindow("bounce_final", 20, 11, -1);
    checkSteady("bounce_final", 1'b1, 1'b0, 8'd2);
    applyStimulus(1'b1);
    watchWindow("bounce_release", 20, -1, 11);
    checkSteady("bounce_release", 1'b0, 1'b0, 8'd2);

    // Reset mid-qualification: PRESS_CHK is entered at e=2, so the counter
    // holds 5 after e=7. Reset is taken on the next edge. Everything clears
    // with no pulse, and the still-held button is re-qualified at full latency.
    applyStimulus(1'b0);
    watchWindow("midrst_pre", 8, -1, -1);
    rstN = 1'b0;
    stepEdge();
    rstN = 1'b1;
    checkOutput("midrst_press", 8'(btnPress), 8'd0);
    checkOutput("midrst_release", 8'(btnRelease), 8'd0);
    checkSteady("midrst", 1'b0, 1'b0, 8'd0);
    watchWindow("midrst_repress", 20, 11, -1);
    checkSteady("midrst_repress", 1'b1, 1'b1, 8'd1);
    applyStimulus(1'b1);
    watchWindow("midrst_release", 20, -1, 11);

    // Counter wrap: clear with reset, then make 256 accepted presses.
    rstN = 1'b0;
    stepEdge();
    rstN = 1'b1;
    checkSteady("wrap_start", 1'b0, 1'b0, 8'd0);
    for (int i = 1; i <= 256; i++) begin
      applyStimulus(1'b0);
      repeat (14) stepEdge();
      checkOutput($sformatf("wrap_count_%0d", i), pressCount, 8'(i));
      checkOutput($sformatf("wrap_toggle_%0d", i), 8'(pressToggle), 8'(i % 2));
      applyStimulus(1'b1);
      repeat (14) stepEdge();
    end
    checkSteady("wrap_end", 1'b0, 1'b0, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
